// File: rtl/hoene_led_pkg.sv
// Shared types and constants for the smart-LED frame controller.
package hoene_led_pkg;

   localparam int DEFAULT_PWM_BITS = 10;
   localparam int FRAME_BITS       = 2 + 3*DEFAULT_PWM_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      FORWARD = 2'd2,
      ERROR   = 2'd3
   } state_t;

   localparam logic [1:0] CMD_NOP           = 2'b00;
   localparam logic [1:0] CMD_SET           = 2'b01;
   localparam logic [1:0] CMD_SET_FWD_BLANK = 2'b10;
   localparam logic [1:0] CMD_RSVD          = 2'b11;

   // Both SET flavours commit colours locally; NOP and reserved do nothing.
   function automatic logic is_set_cmd(input logic [1:0] cmd);
      return (cmd == CMD_SET) || (cmd == CMD_SET_FWD_BLANK);
   endfunction

endpackage

// File: rtl/hoene_frame_shifter.sv
// Shadow shift register and bit counter for this LED's frame word.
module hoene_frame_shifter
   import hoene_led_pkg::*;
#(
   parameter int WORD_BITS = FRAME_BITS,
   parameter int CNT_W     = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 shift,
   input  logic                 bit_in,
   output logic [WORD_BITS-1:0] word,
   output logic                 last_bit
);

   logic [CNT_W-1:0] count;

   // High on the strobe that carries the final bit of the word.
   assign last_bit = shift && (count == CNT_W'(WORD_BITS-1));

   // MSB-first shift; the controller stops shifting once the word is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word  <= '0;
         count <= '0;
      end else if (clear) begin
         word  <= '0;
         count <= '0;
      end else if (shift) begin
         word  <= {word[WORD_BITS-2:0], bit_in};
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hoene_led_frame_controller.sv
// Frame sequencer: collects this LED's word, forwards the rest, commits on clean end.
module hoene_led_frame_controller
   import hoene_led_pkg::*;
#(
   parameter int PWM_BITS       = DEFAULT_PWM_BITS,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_data,
   input  logic                in_strobe,
   input  logic                in_error,
   input  logic                in_sync,
   output logic [PWM_BITS-1:0] out_red,
   output logic [PWM_BITS-1:0] out_green,
   output logic [PWM_BITS-1:0] out_blue,
   output logic                out_load,
   output logic                out_forward,
   output logic                out_busy,
   output logic                out_frame_error
);

   localparam int FRAME_W = 2 + 3*PWM_BITS;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state;
   logic               sync_q;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [FRAME_W-1:0] word;
   logic               last_bit;
   logic               sync_rise;
   logic               timeout;
   logic               clear;
   logic               shift;
   logic [1:0]         cmd;

   assign sync_rise = in_sync && !sync_q;
   assign timeout   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
   assign clear     = (state == IDLE) && sync_rise;
   // A strobe only counts when nothing of higher precedence happens in that cycle.
   assign shift     = (state == RECEIVE) && in_strobe && !in_error && in_sync && !timeout;
   assign cmd       = word[FRAME_W-1 -: 2];

   hoene_frame_shifter #(
      .WORD_BITS (FRAME_W),
      .CNT_W     (CNT_W)
   ) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .shift    (shift),
      .bit_in   (in_data),
      .word     (word),
      .last_bit (last_bit)
   );

   // Previous in_sync for frame-start edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 1'b0;
      else        sync_q <= in_sync;
   end

   // Frame state machine with timeout counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         tmo_cnt         <= '0;
         out_red         <= '0;
         out_green       <= '0;
         out_blue        <= '0;
         out_load        <= 1'b0;
         out_forward     <= 1'b0;
         out_busy        <= 1'b0;
         out_frame_error <= 1'b0;
      end else begin
         out_load <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_rise) begin
                  state           <= RECEIVE;
                  out_busy        <= 1'b1;
                  out_frame_error <= 1'b0;
                  tmo_cnt         <= '0;
               end
            end
            RECEIVE: begin
               if (in_error) begin
                  state           <= ERROR;
                  out_frame_error <= 1'b1;
               end else if (!in_sync) begin
                  // Short frame: word incomplete, never committed.
                  state           <= IDLE;
                  out_busy        <= 1'b0;
                  out_frame_error <= 1'b1;
               end else if (timeout) begin
                  state           <= ERROR;
                  out_frame_error <= 1'b1;
               end else if (in_strobe) begin
                  tmo_cnt <= '0;
                  if (last_bit) begin
                     state       <= FORWARD;
                     out_forward <= 1'b1;
                  end
               end else begin
                  // Stops at TIMEOUT_CYCLES because the timeout branch wins there.
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            FORWARD: begin
               if (in_error) begin
                  state           <= ERROR;
                  out_forward     <= 1'b0;
                  out_frame_error <= 1'b1;
               end else if (!in_sync) begin
                  state       <= IDLE;
                  out_forward <= 1'b0;
                  out_busy    <= 1'b0;
                  if (is_set_cmd(cmd)) begin
                     out_red   <= word[3*PWM_BITS-1 -: PWM_BITS];
                     out_green <= word[2*PWM_BITS-1 -: PWM_BITS];
                     out_blue  <= word[PWM_BITS-1:0];
                     out_load  <= 1'b1;
                  end
               end
            end
            ERROR: begin
               out_frame_error <= 1'b1;
               if (!in_sync) begin
                  state    <= IDLE;
                  out_busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               out_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hoene_led_frame_controller.sv
// Self-checking bench for hoene_led_frame_controller with a load scoreboard.
module tb_hoene_led_frame_controller;

   typedef struct packed {
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
   } col_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_data = 1'b0;
   logic       in_strobe = 1'b0;
   logic       in_error = 1'b0;
   logic       in_sync = 1'b0;
   logic [9:0] out_red, out_green, out_blue;
   logic       out_load, out_forward, out_busy, out_frame_error;

   col_t exp_q[$];
   col_t cur = '0;
   int   total = 0;
   int   bad = 0;
   int   loads = 0;

   always #5 clk = ~clk;

   hoene_led_frame_controller #(.PWM_BITS(10), .TIMEOUT_CYCLES(4095)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_data         (in_data),
      .in_strobe       (in_strobe),
      .in_error        (in_error),
      .in_sync         (in_sync),
      .out_red         (out_red),
      .out_green       (out_green),
      .out_blue        (out_blue),
      .out_load        (out_load),
      .out_forward     (out_forward),
      .out_busy        (out_busy),
      .out_frame_error (out_frame_error)
   );

   // Scoreboard: every load pulse must match the oldest expected commit.
   always @(negedge clk) begin
      col_t e;
      if (out_load === 1'b1) begin
         loads++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL load_unexpected got=%h_%h_%h expected no load", out_red, out_green, out_blue);
         end else begin
            e = exp_q.pop_front();
            if ({out_red, out_green, out_blue} !== e) begin
               bad++;
               $display("FAIL load_value got=%h_%h_%h expected=%h_%h_%h",
                        out_red, out_green, out_blue, e.r, e.g, e.b);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk(input logic [1:0] c, input logic [9:0] r,
                                      input logic [9:0] g, input logic [9:0] b);
      return {c, r, g, b};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      in_data = b; in_strobe = 1'b1; tick(1);
      in_strobe = 1'b0; tick(1);
   endtask

   task automatic sync_up();
      in_sync = 1'b1; tick(2);
   endtask

   task automatic sync_down();
      in_sync = 1'b0; tick(3);
   endtask

   // Full clean frame; expected commit is queued only for SET commands.
   task automatic play_frame(input logic [31:0] w);
      sync_up();
      for (int i = 0; i < 32; i++) send_bit(w[31-i]);
      if (w[31:30] == 2'b01 || w[31:30] == 2'b10) begin
         cur = w[29:0];
         exp_q.push_back(cur);
      end
      tick(1);
      sync_down();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick(2);
      total++; if (out_red !== 10'h0) begin bad++; $display("FAIL rst_red got=%h expected=0", out_red); end
      total++; if (out_green !== 10'h0) begin bad++; $display("FAIL rst_green got=%h expected=0", out_green); end
      total++; if (out_blue !== 10'h0) begin bad++; $display("FAIL rst_blue got=%h expected=0", out_blue); end
      total++; if (out_load !== 1'b0) begin bad++; $display("FAIL rst_load got=%b expected=0", out_load); end
      total++; if (out_forward !== 1'b0) begin bad++; $display("FAIL rst_fwd got=%b expected=0", out_forward); end
      total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b expected=0", out_busy); end
      total++; if (out_frame_error !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b expected=0", out_frame_error); end
      rst_n = 1'b1; tick(2);
   endtask

   task automatic test_good_set();
      logic [31:0] w;
      int l0;
      w = mk(2'b01, 10'h3FF, 10'h155, 10'h001);
      l0 = loads;
      sync_up();
      total++; if (out_busy !== 1'b1) begin bad++; $display("FAIL set_busy got=%b expected=1", out_busy); end
      for (int i = 0; i < 31; i++) send_bit(w[31-i]);
      total++; if (out_forward !== 1'b0) begin bad++; $display("FAIL set_fwd_early got=%b expected=0", out_forward); end
      in_data = w[0]; in_strobe = 1'b1; tick(1); in_strobe = 1'b0;
      total++; if (out_forward !== 1'b1) begin bad++; $display("FAIL set_fwd_after32 got=%b expected=1", out_forward); end
      cur = w[29:0];
      exp_q.push_back(cur);
      tick(1);
      total++; if (out_load !== 1'b0) begin bad++; $display("FAIL set_load_early got=%b expected=0", out_load); end
      sync_down();
      total++; if (loads !== l0 + 1) begin bad++; $display("FAIL set_load_count got=%0d expected=%0d", loads, l0 + 1); end
      total++; if ({out_red, out_green, out_blue} !== cur) begin bad++; $display("FAIL set_hold got=%h expected=%h", {out_red, out_green, out_blue}, cur); end
      total++; if (out_frame_error !== 1'b0) begin bad++; $display("FAIL set_ferr got=%b expected=0", out_frame_error); end
      total++; if (out_busy !== 1'b0 || out_forward !== 1'b0) begin bad++; $display("FAIL set_idle got=%b%b expected=00", out_busy, out_forward); end
   endtask

   task automatic test_chained();
      logic [31:0] w;
      int l0, low;
      w = mk(2'b10, 10'h2A5, 10'h0F0, 10'h33C);
      l0 = loads; low = 0;
      sync_up();
      for (int i = 0; i < 32; i++) send_bit(w[31-i]);
      cur = w[29:0];
      exp_q.push_back(cur);
      for (int i = 0; i < 40; i++) begin
         send_bit(1'($urandom_range(0, 1)));
         if (out_forward !== 1'b1) low++;
      end
      total++; if (low !== 0) begin bad++; $display("FAIL chain_fwd_low got=%0d expected=0", low); end
      sync_down();
      total++; if (out_forward !== 1'b0) begin bad++; $display("FAIL chain_fwd_end got=%b expected=0", out_forward); end
      total++; if (loads !== l0 + 1) begin bad++; $display("FAIL chain_load_count got=%0d expected=%0d", loads, l0 + 1); end
      total++; if ({out_red, out_green, out_blue} !== cur) begin bad++; $display("FAIL chain_colour got=%h expected=%h", {out_red, out_green, out_blue}, cur); end
   endtask

   task automatic test_short();
      logic [31:0] w;
      int l0;
      w = mk(2'b01, 10'h111, 10'h222, 10'h333);
      l0 = loads;
      sync_up();
      for (int i = 0; i < 20; i++) send_bit(w[31-i]);
      sync_down();
      total++; if (loads !== l0) begin bad++; $display("FAIL short_load got=%0d expected=%0d", loads, l0); end
      total++; if ({out_red, out_green, out_blue} !== cur) begin bad++; $display("FAIL short_colour got=%h expected=%h", {out_red, out_green, out_blue}, cur); end
      total++; if (out_frame_error !== 1'b1) begin bad++; $display("FAIL short_ferr got=%b expected=1", out_frame_error); end
      total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL short_busy got=%b expected=0", out_busy); end
      in_sync = 1'b1; tick(1);
      total++; if (out_frame_error !== 1'b0) begin bad++; $display("FAIL short_ferr_clear got=%b expected=0", out_frame_error); end
      in_sync = 1'b0; tick(2);
   endtask

   task automatic test_error();
      logic [31:0] w;
      int l0;
      w = mk(2'b01, 10'h0AA, 10'h0BB, 10'h0CC);
      l0 = loads;
      sync_up();
      for (int i = 0; i < 10; i++) send_bit(w[31-i]);
      in_error = 1'b1; in_strobe = 1'b1; in_data = 1'b1; tick(1);
      in_error = 1'b0; in_strobe = 1'b0; tick(1);
      total++; if (out_frame_error !== 1'b1) begin bad++; $display("FAIL err_ferr got=%b expected=1", out_frame_error); end
      for (int i = 0; i < 25; i++) send_bit(1'b1);
      total++; if (out_busy !== 1'b1) begin bad++; $display("FAIL err_busy got=%b expected=1", out_busy); end
      total++; if (out_forward !== 1'b0) begin bad++; $display("FAIL err_fwd got=%b expected=0", out_forward); end
      sync_down();
      total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL err_busy_end got=%b expected=0", out_busy); end
      total++; if (loads !== l0) begin bad++; $display("FAIL err_load got=%0d expected=%0d", loads, l0); end
      total++; if (out_frame_error !== 1'b1) begin bad++; $display("FAIL err_ferr_hold got=%b expected=1", out_frame_error); end
      // Error after a full word discards it.
      sync_up();
      for (int i = 0; i < 32; i++) send_bit(w[31-i]);
      in_error = 1'b1; tick(1); in_error = 1'b0; tick(1);
      total++; if (out_forward !== 1'b0 || out_frame_error !== 1'b1) begin bad++; $display("FAIL fwd_err got=%b%b expected=01", out_forward, out_frame_error); end
      sync_down();
      total++; if (loads !== l0) begin bad++; $display("FAIL fwd_err_load got=%0d expected=%0d", loads, l0); end
      total++; if ({out_red, out_green, out_blue} !== cur) begin bad++; $display("FAIL fwd_err_colour got=%h expected=%h", {out_red, out_green, out_blue}, cur); end
   endtask

   task automatic test_timeout();
      int n, l0;
      l0 = loads;
      n = 0;
      sync_up();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      while (out_frame_error !== 1'b1 && n < 5000) begin tick(1); n++; end
      total++; if (n < 4090 || n > 4100) begin bad++; $display("FAIL timeout_cycles got=%0d expected=4095", n); end
      total++; if (out_busy !== 1'b1) begin bad++; $display("FAIL timeout_busy got=%b expected=1", out_busy); end
      sync_down();
      total++; if (out_busy !== 1'b0 || loads !== l0) begin bad++; $display("FAIL timeout_end got=%b/%0d expected=0/%0d", out_busy, loads, l0); end
      play_frame(mk(2'b01, 10'h155, 10'h2AA, 10'h3C3));
      total++; if (loads !== l0 + 1) begin bad++; $display("FAIL timeout_next_load got=%0d expected=%0d", loads, l0 + 1); end
      total++; if (out_frame_error !== 1'b0) begin bad++; $display("FAIL timeout_next_ferr got=%b expected=0", out_frame_error); end
   endtask

   task automatic test_nop_reset();
      logic [31:0] w;
      int l0;
      l0 = loads;
      play_frame(mk(2'b00, 10'h001, 10'h002, 10'h003));
      play_frame(mk(2'b11, 10'h004, 10'h005, 10'h006));
      total++; if (loads !== l0) begin bad++; $display("FAIL nop_load got=%0d expected=%0d", loads, l0); end
      total++; if ({out_red, out_green, out_blue} !== cur) begin bad++; $display("FAIL nop_colour got=%h expected=%h", {out_red, out_green, out_blue}, cur); end
      w = mk(2'b01, 10'h321, 10'h123, 10'h2F0);
      sync_up();
      for (int i = 0; i < 24; i++) send_bit(w[31-i]);
      in_data = w[7]; in_strobe = 1'b1; rst_n = 1'b0; #1;
      total++; if ({out_red, out_green, out_blue} !== 30'h0) begin bad++; $display("FAIL rst_mid_colour got=%h expected=0", {out_red, out_green, out_blue}); end
      total++; if (out_busy !== 1'b0 || out_frame_error !== 1'b0 || out_forward !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got=%b%b%b expected=000", out_busy, out_frame_error, out_forward); end
      in_strobe = 1'b0; in_sync = 1'b0; cur = '0;
      tick(2); rst_n = 1'b1; tick(2);
      total++; if (out_load !== 1'b0 || {out_red, out_green, out_blue} !== 30'h0) begin bad++; $display("FAIL rst_mid_commit got=%b/%h expected=0/0", out_load, {out_red, out_green, out_blue}); end
      l0 = loads;
      play_frame(w);
      total++; if (loads !== l0 + 1) begin bad++; $display("FAIL rst_next_load got=%0d expected=%0d", loads, l0 + 1); end
      total++; if ({out_red, out_green, out_blue} !== w[29:0]) begin bad++; $display("FAIL rst_next_colour got=%h expected=%h", {out_red, out_green, out_blue}, w[29:0]); end
   endtask

   initial begin
      test_reset();
      test_good_set();
      test_chained();
      test_short();
      test_error();
      test_timeout();
      test_nop_reset();
      tick(3);
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d expected=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
